// File: rtl/overlay_writer.sv
// Draws a (4*ARM+1)-pixel plus marker per feature point as byte-masked SRAM write beats.
// Latency: first beat valid two edges after point accept; 1 beat/cycle; stalls while valid && !ready.
module overlay_writer #(
  parameter int         WIDTH       = 800,
  parameter int         HEIGHT      = 600,
  parameter int         ARM         = 2,
  parameter logic [7:0] COLOR       = 8'hFF,
  parameter int         FRAME_WORDS = 120000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pt_valid,
  output logic        pt_ready,
  input  logic [9:0]  pt_x,
  input  logic [9:0]  pt_y,
  input  logic        pt_last,
  input  logic        buffer_sel,
  output logic [53:0] dout,
  output logic        valid,
  input  logic        ready,
  output logic        done
);

  typedef enum logic [2:0] {IDLE, DRAW_H, DRAW_V, DRAIN, DONE} state_t;

  localparam logic signed [3:0] D_MIN = 4'(-ARM);
  localparam logic signed [3:0] D_MAX = 4'(ARM);

  state_t             state_q, state_d;
  logic [9:0]         x_q, x_d, y_q, y_d;
  logic               last_q, last_d, sel_q, sel_d;
  logic signed [3:0]  d_q, d_d;
  logic               fresh_q, fresh_d;
  logic               live_q;
  logic               valid_q, valid_d;
  logic [53:0]        dout_q, dout_d;

  logic signed [11:0] dext, px, py;
  logic               pt_ok, inb, adv;
  logic [18:0]        pix;
  logic [17:0]        addr;
  logic [3:0]         mask;

  // Offset applies to the column while drawing the arm across, to the row while drawing down.
  always_comb begin
    dext  = {{8{d_q[3]}}, d_q};
    px    = $signed({2'b00, x_q}) + ((state_q == DRAW_H) ? dext : 12'sd0);
    py    = $signed({2'b00, y_q}) + ((state_q == DRAW_V) ? dext : 12'sd0);
    pt_ok = ({2'b00, x_q} < 12'(WIDTH)) && ({2'b00, y_q} < 12'(HEIGHT));
    inb   = pt_ok && !px[11] && !py[11] &&
            (px < $signed(12'(WIDTH))) && (py < $signed(12'(HEIGHT)));
    pix   = 19'(py[9:0]) * 19'(WIDTH) + 19'(px[9:0]);
    addr  = 18'(pix >> 2) + (sel_q ? 18'(FRAME_WORDS) : 18'd0);
    mask  = 4'b0001 << pix[1:0];
    adv   = ((state_q == DRAW_H) || (state_q == DRAW_V)) && !fresh_q && (!valid_q || ready);
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    last_d  = last_q;
    sel_d   = sel_q;
    d_d     = d_q;
    fresh_d = 1'b0;
    valid_d = valid_q && !ready;
    dout_d  = dout_q;
    if (adv && inb) begin
      valid_d = 1'b1;
      dout_d  = {mask, addr, {4{COLOR}}};
    end
    case (state_q)
      IDLE: begin
        if (pt_valid && pt_ready) begin
          x_d     = pt_x;
          y_d     = pt_y;
          last_d  = pt_last;
          sel_d   = buffer_sel;
          d_d     = D_MIN;
          fresh_d = 1'b1;
          state_d = DRAW_H;
        end
      end
      DRAW_H: begin
        if (adv) begin
          if (d_q == D_MAX) begin
            d_d     = D_MIN;
            state_d = DRAW_V;
          end else begin
            d_d = d_q + 4'sd1;
          end
        end
      end
      DRAW_V: begin
        if (adv) begin
          if (d_q == D_MAX) begin
            state_d = last_q ? DRAIN : IDLE;
          end else begin
            // centre pixel was already drawn by the horizontal arm
            d_d = (d_q == -4'sd1) ? 4'sd1 : d_q + 4'sd1;
          end
        end
      end
      DRAIN: begin
        if (!valid_q) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      last_q  <= 1'b0;
      sel_q   <= 1'b0;
      d_q     <= '0;
      fresh_q <= 1'b0;
      live_q  <= 1'b0;
      valid_q <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      d_q     <= d_d;
      fresh_q <= fresh_d;
      live_q  <= 1'b1;
      valid_q <= valid_d;
      dout_q  <= dout_d;
    end
  end

  // live_q keeps pt_ready low while reset is held and until the first edge after release.
  assign pt_ready = (state_q == IDLE) && live_q;
  assign valid    = valid_q;
  assign dout     = dout_q;
  assign done     = (state_q == DONE);

endmodule

// File: tb/tb_overlay_writer.sv
// Directed bench for overlay_writer: beat order/content, clipping, buffer select,
// backpressure hold, frame-end done pulse and asynchronous reset mid-draw.
module tb_overlay_writer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        pt_valid = 1'b0;
  logic        pt_ready;
  logic [9:0]  pt_x = '0;
  logic [9:0]  pt_y = '0;
  logic        pt_last = 1'b0;
  logic        buffer_sel = 1'b0;
  logic [53:0] dout;
  logic        valid;
  logic        ready = 1'b1;
  logic        done;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int hold_err = 0;
  int rdy_err = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int last_beat_cyc = 0;
  bit watch_rdy = 1'b0;
  logic        pv = 1'b0;
  logic        pr = 1'b0;
  logic [53:0] pd = '0;
  logic [53:0] beats[$];
  logic [53:0] exp_q[$];

  overlay_writer dut (
    .clock(clock), .reset(reset), .pt_valid(pt_valid), .pt_ready(pt_ready),
    .pt_x(pt_x), .pt_y(pt_y), .pt_last(pt_last), .buffer_sel(buffer_sel),
    .dout(dout), .valid(valid), .ready(ready), .done(done)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Passive monitor on the falling edge: logs handshaken beats, hold violations, done pulses.
  always @(negedge clock) begin
    if (!reset) begin
      pv = 1'b0;
    end else begin
      if (pv && !pr && (!valid || dout !== pd)) hold_err++;
      if (valid && ready) begin
        beats.push_back(dout);
        last_beat_cyc = cyc;
      end
      if (watch_rdy && pt_ready) rdy_err++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        watch_rdy = 1'b0;
      end
      pv = valid;
      pr = ready;
      pd = dout;
    end
  end

  function automatic logic [53:0] bt(input logic [3:0] m, input logic [17:0] a);
    return {m, a, 32'hFFFF_FFFF};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_point(input int x, input int y, input logic last, input logic sel);
    int n;
    pt_x = 10'(x);
    pt_y = 10'(y);
    pt_last = last;
    buffer_sel = sel;
    pt_valid = 1'b1;
    n = 0;
    while (!pt_ready && n < 60) begin
      tick();
      n++;
    end
    check("accept_ready", 64'(pt_ready), 64'd1);
    tick();
    pt_valid = 1'b0;
  endtask

  task automatic wait_beats(input int n, input bit bp);
    int k;
    k = 0;
    while ((beats.size() < n || valid) && k < 300) begin
      tick();
      if (bp) ready = ~ready;
      k++;
    end
    ready = 1'b1;
    repeat (6) tick();
  endtask

  task automatic compare_beats(input string tag);
    int n;
    check({tag, "_count"}, 64'(beats.size()), 64'(exp_q.size()));
    n = (beats.size() < exp_q.size()) ? beats.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_beat%0d", tag, i), 64'(beats[i]), 64'(exp_q[i]));
  endtask

  task automatic load_mid();
    exp_q = {bt(4'b0100, 10024), bt(4'b1000, 10024), bt(4'b0001, 10025),
             bt(4'b0010, 10025), bt(4'b0100, 10025),
             bt(4'b0001, 9625), bt(4'b0001, 9825), bt(4'b0001, 10225), bt(4'b0001, 10425)};
  endtask

  initial begin
    int k;
    int d0;

    // Reset state
    #13;
    check("rst_pt_ready", 64'(pt_ready), 64'd0);
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_dout", 64'(dout), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    tick();
    reset = 1'b1;
    check("rel_pt_ready_pre_edge", 64'(pt_ready), 64'd0);
    tick();
    check("idle_pt_ready", 64'(pt_ready), 64'd1);

    // Mid-image point with latency check
    beats.delete();
    load_mid();
    send_point(100, 50, 1'b0, 1'b0);
    check("lat_n_plus1", 64'(valid), 64'd0);
    tick();
    check("lat_n_plus1b", 64'(valid), 64'd0);
    tick();
    check("lat_n_plus2_valid", 64'(valid), 64'd1);
    check("lat_n_plus2_dout", 64'(dout), 64'(exp_q[0]));
    wait_beats(9, 1'b0);
    compare_beats("mid");

    // Corner clip
    beats.delete();
    exp_q = {bt(4'b0001, 0), bt(4'b0010, 0), bt(4'b0100, 0), bt(4'b0001, 200), bt(4'b0001, 400)};
    send_point(0, 0, 1'b0, 1'b0);
    wait_beats(5, 1'b0);
    compare_beats("corner");

    // Buffer select, point fields scrambled after accept
    beats.delete();
    exp_q = {bt(4'b0001, 120000), bt(4'b0010, 120000), bt(4'b0100, 120000),
             bt(4'b0001, 120200), bt(4'b0001, 120400)};
    send_point(0, 0, 1'b0, 1'b1);
    buffer_sel = 1'b0;
    pt_x = 10'd333;
    pt_y = 10'd77;
    tick();
    buffer_sel = 1'b1;
    tick();
    buffer_sel = 1'b0;
    wait_beats(5, 1'b0);
    compare_beats("bufsel");

    // Backpressure on alternate cycles
    beats.delete();
    load_mid();
    hold_err = 0;
    send_point(100, 50, 1'b0, 1'b0);
    wait_beats(9, 1'b1);
    compare_beats("bp");
    check("bp_hold_stable", 64'(hold_err), 64'd0);

    // Frame end: in-range point then out-of-range last point
    beats.delete();
    exp_q = {bt(4'b0001, 2002), bt(4'b0010, 2002), bt(4'b0100, 2002), bt(4'b1000, 2002),
             bt(4'b0001, 2003), bt(4'b0100, 1602), bt(4'b0100, 1802), bt(4'b0100, 2202),
             bt(4'b0100, 2402)};
    done_cnt = 0;
    send_point(10, 10, 1'b0, 1'b0);
    wait_beats(9, 1'b0);
    compare_beats("frame_pt");
    check("frame_no_early_done", 64'(done_cnt), 64'd0);
    beats.delete();
    rdy_err = 0;
    send_point(800, 0, 1'b1, 1'b0);
    watch_rdy = 1'b1;
    k = 0;
    while (done_cnt == 0 && k < 100) begin
      tick();
      k++;
    end
    check("frame_pt_ready_after_done", 64'(pt_ready), 64'd1);
    repeat (8) tick();
    watch_rdy = 1'b0;
    check("frame_oob_zero_beats", 64'(beats.size()), 64'd0);
    check("frame_done_count", 64'(done_cnt), 64'd1);
    check("frame_pt_ready_low", 64'(rdy_err), 64'd0);

    // Done timing on an in-range last point
    beats.delete();
    done_cnt = 0;
    send_point(5, 5, 1'b1, 1'b0);
    wait_beats(9, 1'b0);
    repeat (4) tick();
    check("last_beats", 64'(beats.size()), 64'd9);
    check("last_done_count", 64'(done_cnt), 64'd1);
    check("last_done_timing", 64'(done_cyc - last_beat_cyc), 64'd2);

    // Reset mid-draw
    beats.delete();
    done_cnt = 0;
    send_point(100, 50, 1'b1, 1'b0);
    k = 0;
    while (beats.size() < 3 && k < 50) begin
      tick();
      k++;
    end
    check("rstmid_three_beats", 64'(beats.size()), 64'd3);
    reset = 1'b0;
    #1;
    check("rstmid_valid", 64'(valid), 64'd0);
    check("rstmid_dout", 64'(dout), 64'd0);
    check("rstmid_pt_ready", 64'(pt_ready), 64'd0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("rstmid_idle_ready", 64'(pt_ready), 64'd1);
    repeat (10) tick();
    check("rstmid_no_done", 64'(done_cnt), 64'd0);
    d0 = beats.size();
    check("rstmid_no_partial", 64'(d0), 64'd3);
    beats.delete();
    load_mid();
    send_point(100, 50, 1'b0, 1'b0);
    wait_beats(9, 1'b0);
    compare_beats("after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/overlay_writer.md
# overlay_writer

Draws a plus-shaped marker into the SRAM frame buffer for every feature point it receives, issuing byte-masked writes on the arbiter's W1 overlay-writer port. It sits downstream of the feature detector's point stream and directly upstream of the SRAM arbiter. It uses the same 54-bit {mask, addr, data} write-beat format as the image buffer writer on W0.

## Interface
Parameters:
- WIDTH, 800: image width in pixels.
- HEIGHT, 600: image height in pixels.
- ARM, 2: marker arm length in pixels (1..7).
- COLOR, 8'hFF: 8-bit marker pixel value.
- FRAME_WORDS, 120000: words per frame buffer (WIDTH*HEIGHT/4).

Ports:
- clock  in  1  single clock (10 MHz domain, shared with the W1 port).
- reset  in  1  asynchronous, active-low reset.
- pt_valid  in  1  feature point valid.
- pt_ready  out  1  feature point accepted when pt_valid && pt_ready.
- pt_x  in  10  point column.
- pt_y  in  10  point row.
- pt_last  in  1  point is the last of its frame.
- buffer_sel  in  1  target frame buffer; sampled at point accept.
- dout  out  54  {mask[53:50], addr[49:32], data[31:0]} write beat.
- valid  out  1  dout valid.
- ready  in  1  arbiter W1 accepts the beat when valid && ready.
- done  out  1  one-cycle pulse when a pt_last point is fully written.

## Operation
- Pixel packing: 4 pixels per 32-bit word, little-endian lanes.
  - Pixel index p = y*WIDTH + x, 19 bits, constant multiply.
  - addr = (buffer_sel ? FRAME_WORDS : 0) + (p >> 2), 18 bits, no overflow (max 239999).
  - mask = 4'b0001 << p[1:0]; mask bits are active-high byte enables.
  - data = {4{COLOR}}.
- FSM states: IDLE, DRAW_H, DRAW_V, DRAIN, DONE.
  - IDLE: pt_ready=1. On accept, latch x, y, last, and buffer_sel; set offset d=-ARM; go to DRAW_H.
  - DRAW_H: one step per advance; generate pixel (x+d, y) for d=-ARM..+ARM. After d=+ARM, set d=-ARM and go to DRAW_V.
  - DRAW_V: generate pixel (x, y+d) for d=-ARM..+ARM, skipping d=0 so the centre is written once. After d=+ARM, go to DRAIN if last, else IDLE.
  - DRAIN: wait until valid==0, then go to DONE.
  - DONE: assert done for one cycle, then go to IDLE.
- Advance condition in DRAW_*: output register empty or being consumed, i.e. !valid || ready.
  - In-bounds pixel: loaded into the output register.
  - Out-of-bounds pixel (coordinate <0 or >=WIDTH/HEIGHT): consumes the step, emits no beat.
- Input points with x>=WIDTH or y>=HEIGHT are accepted and emit zero beats; pt_last on such a point still produces done.
- pt_ready is low in DRAW_H, DRAW_V, DRAIN, and DONE. Next point accept can overlap the last pending beat of the previous point.

## Timing
- Reset values: pt_ready=0 during reset, 1 in IDLE after release; valid=0, dout=0, done=0; FSM=IDLE.
- Reset mid-draw: all state cleared immediately (asynchronous); no partial beat remains and no done is issued.
- Latency: point accepted at edge N, first beat valid from edge N+2 if its offset is in bounds.
- Throughput: one beat per cycle with ready held high.
  - A full in-bounds marker is 4*ARM+1 beats, taking 4*ARM+1 cycles of FSM stepping.
- Output hold: while valid && !ready, dout and valid are held stable and FSM stepping stalls.
- done: asserted exactly one cycle after the final beat of a last point is handshaken, or 2 cycles after DRAW_V ends if no beat was pending.
- buffer_sel and point fields changing after accept have no effect on the marker in progress.

## Test plan
- Mid-image point: (100,50), sel=0, ready=1 → 9 beats in order, data=32'hFFFFFFFF:
  - horizontal: 10024/0100, 10024/1000, 10025/0001, 10025/0010, 10025/0100;
  - vertical: 9625/0001, 9825/0001, 10225/0001, 10425/0001.
- Corner clip: (0,0), sel=0 → 5 beats: 0/0001, 0/0010, 0/0100, 200/0001, 400/0001.
- Buffer select: (0,0) with sel=1 → same 5 beats at addresses 120000, 120000, 120000, 120200, 120400. Toggling sel mid-marker changes nothing.
- Backpressure: (100,50) with ready low on alternate cycles → same 9 beats in order, each held stable while ready=0, no duplicates.
- Frame end: points (10,10) then (800,0) with pt_last=1 → 9 beats, then zero beats for the out-of-range point; one done pulse after the last (10,10) beat is accepted; pt_ready low until done completes.
- Reset mid-draw: assert reset low after the 3rd beat of (100,50) → valid=0, pt_ready returns high in IDLE after release, no done pulse, next point draws fully.
